// File: rtl/dev_bus_bridge_pkg.sv
// rtl/dev_bus_bridge_pkg.sv - shared constants for the device bus bridge
// Purpose: FSM state encoding and device-window geometry used by the bridge
//          and its address decoder.
// Ports:   none (package).
package dev_bus_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam int          SLOT_BYTES        = 16;
  localparam int          MAX_DEV           = 6;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_7F00;

endpackage

// File: rtl/dev_bus_bridge_decode.sv
// rtl/dev_bus_bridge_decode.sv - combinational device-slot address decoder
// Purpose: maps a CPU byte address onto a device slot inside the bridge window.
// Ports:   addr   - CPU byte address
//          access - load or store strobe active
//          hit    - access to a populated slot
//          bad    - access inside the window but to an unpopulated slot
//          idx    - slot index (valid with hit)
//          off    - byte offset inside the slot
module dev_addr_decode
  import dev_bus_bridge_pkg::*;
#(
  parameter int          N_DEV     = 4,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic [31:0] addr,
  input  logic        access,
  output logic        hit,
  output logic        bad,
  output logic [2:0]  idx,
  output logic [3:0]  off
);

  logic [31:0] offset;
  logic        win;

  // Window spans MAX_DEV slots of SLOT_BYTES each. Below BASE_ADDR the
  // subtraction wraps, so the lower bound is checked explicitly.
  always_comb begin
    offset = addr - BASE_ADDR;
    win    = (addr >= BASE_ADDR) && (offset[31:7] == 25'd0) &&
             (int'(offset[6:4]) < MAX_DEV);
    idx    = offset[6:4];
    // BASE_ADDR is slot aligned, so the low nibble equals addr[3:0].
    off    = offset[3:0];
    hit    = access && win && (int'(offset[6:4]) < N_DEV);
    bad    = access && win && (int'(offset[6:4]) >= N_DEV);
  end

endmodule

// File: rtl/dev_bus_bridge.sv
// rtl/dev_bus_bridge.sv - stall-capable CPU to device bus bridge
// Purpose: decodes CPU accesses to device slots, runs a req/ack handshake
//          while stalling the pipeline, reports bus errors and registers
//          device interrupts onto the CP0 hardware interrupt lines.
// Ports:   Clk, Reset (async, active low)
//          PrAddr/PrWD/PrBE/PrWE/PrRE - CPU MEM-stage access
//          PrRD/PrStall/PrBusErr      - CPU response
//          HWInt[7:2]                 - registered device interrupts
//          DEV_Addr/WD/BE/WE/Req      - latched device request
//          DEV_Ack/DEV_RD/DEV_Irq     - per-slot device responses
module dev_bus_bridge
  import dev_bus_bridge_pkg::*;
#(
  parameter int          N_DEV     = 4,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          TIMEOUT   = 15
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [31:0]          PrAddr,
  input  logic [31:0]          PrWD,
  input  logic [3:0]           PrBE,
  input  logic                 PrWE,
  input  logic                 PrRE,
  output logic [31:0]          PrRD,
  output logic                 PrStall,
  output logic                 PrBusErr,
  output logic [7:2]           HWInt,
  output logic [3:0]           DEV_Addr,
  output logic [31:0]          DEV_WD,
  output logic [3:0]           DEV_BE,
  output logic                 DEV_WE,
  output logic [N_DEV-1:0]     DEV_Req,
  input  logic [N_DEV-1:0]     DEV_Ack,
  input  logic [32*N_DEV-1:0]  DEV_RD,
  input  logic [N_DEV-1:0]     DEV_Irq
);

  logic [1:0]  state;
  logic [2:0]  idx_q;
  logic [7:0]  cnt;
  logic [31:0] rdata;
  logic [7:2]  hwint_q;

  logic        hit, bad;
  logic [2:0]  idx;
  logic [3:0]  off;

  logic        ack_sel;
  logic [31:0] rd_sel;
  logic [N_DEV-1:0] slot_onehot;
  logic [7:2]  irq_ext;

  dev_addr_decode #(
    .N_DEV     (N_DEV),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr   (PrAddr),
    .access (PrWE | PrRE),
    .hit    (hit),
    .bad    (bad),
    .idx    (idx),
    .off    (off)
  );

  // Select the latched slot's ack and read data; other slots are ignored.
  always_comb begin
    ack_sel     = 1'b0;
    rd_sel      = 32'd0;
    slot_onehot = '0;
    irq_ext     = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (idx_q == 3'(i)) begin
        ack_sel        = DEV_Ack[i];
        rd_sel         = DEV_RD[32*i +: 32];
        slot_onehot[i] = 1'b1;
      end
      irq_ext[2+i] = DEV_Irq[i];
    end
  end

  // The stall has to rise in the decode cycle itself so the CPU never
  // advances past an access that is about to be sent to a device. Gated
  // by Reset so every output is low while reset is held.
  assign PrStall  = Reset && (((state == ST_IDLE) && hit) || (state == ST_REQ));
  assign PrBusErr = (state == ST_ERR);
  assign PrRD     = (state == ST_DONE) ? rdata : 32'd0;
  assign DEV_Req  = (state == ST_REQ) ? slot_onehot : '0;
  assign HWInt    = hwint_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      idx_q    <= 3'd0;
      DEV_Addr <= 4'd0;
      DEV_WD   <= 32'd0;
      DEV_BE   <= 4'd0;
      DEV_WE   <= 1'b0;
      cnt      <= 8'd0;
      rdata    <= 32'd0;
      hwint_q  <= '0;
    end else begin
      hwint_q <= irq_ext;
      case (state)
        ST_IDLE: begin
          if (hit) begin
            idx_q    <= idx;
            DEV_Addr <= off;
            DEV_WD   <= PrWD;
            DEV_BE   <= PrBE;
            DEV_WE   <= PrWE;
            cnt      <= 8'd0;
            state    <= ST_REQ;
          end else if (bad) begin
            state <= ST_ERR;
          end
        end
        ST_REQ: begin
          cnt <= cnt + 8'd1;
          // Ack is checked first so it wins over a simultaneous timeout.
          if (ack_sel) begin
            rdata <= DEV_WE ? 32'd0 : rd_sel;
            state <= ST_DONE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state <= ST_ERR;
          end
        end
        // DONE ignores hit: the CPU still presents the same instruction.
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dev_bus_bridge.sv
// tb/tb_dev_bus_bridge.sv - directed self-checking bench for dev_bus_bridge
module tb_dev_bus_bridge;

  logic         Clk;
  logic         Reset;
  logic [31:0]  PrAddr, PrWD;
  logic [3:0]   PrBE;
  logic         PrWE, PrRE;
  logic [31:0]  PrRD;
  logic         PrStall, PrBusErr;
  logic [5:0]   HWInt;
  logic [3:0]   DEV_Addr;
  logic [31:0]  DEV_WD;
  logic [3:0]   DEV_BE;
  logic         DEV_WE;
  logic [3:0]   DEV_Req;
  logic [3:0]   DEV_Ack;
  logic [127:0] DEV_RD;
  logic [3:0]   DEV_Irq;

  int pass_cnt = 0;
  int total    = 0;

  dev_bus_bridge #(
    .N_DEV     (4),
    .BASE_ADDR (32'h0000_7F00),
    .TIMEOUT   (15)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .PrAddr   (PrAddr),
    .PrWD     (PrWD),
    .PrBE     (PrBE),
    .PrWE     (PrWE),
    .PrRE     (PrRE),
    .PrRD     (PrRD),
    .PrStall  (PrStall),
    .PrBusErr (PrBusErr),
    .HWInt    (HWInt),
    .DEV_Addr (DEV_Addr),
    .DEV_WD   (DEV_WD),
    .DEV_BE   (DEV_BE),
    .DEV_WE   (DEV_WE),
    .DEV_Req  (DEV_Req),
    .DEV_Ack  (DEV_Ack),
    .DEV_RD   (DEV_RD),
    .DEV_Irq  (DEV_Irq)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change 1 ns after the rising edge, outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (PrStall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", PrStall); else pass_cnt++;
    total++; if (DEV_Req !== 4'b0000) $display("FAIL reset_req got=%b exp=0000", DEV_Req); else pass_cnt++;
    total++; if (PrRD !== 32'd0) $display("FAIL reset_rd got=%h exp=0", PrRD); else pass_cnt++;
    total++; if (HWInt !== 6'd0) $display("FAIL reset_hwint got=%b exp=000000", HWInt); else pass_cnt++;
    total++; if (PrBusErr !== 1'b0) $display("FAIL reset_buserr got=%b exp=0", PrBusErr); else pass_cnt++;
    tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int stall_n = 0;
    tick();
    PrRE = 1'b1; PrAddr = 32'h0000_7F14;
    DEV_RD[31:0] = 32'h1111_1111; DEV_RD[63:32] = 32'hDEAD_BEEF;
    #1;
    if (PrStall) stall_n++;
    total++; if (DEV_Req !== 4'b0000) $display("FAIL read_idle_req got=%b exp=0000", DEV_Req); else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      DEV_Ack = (k == 3) ? 4'b0010 : 4'b0000;
      #1;
      if (PrStall) stall_n++;
      total++; if (DEV_Req !== 4'b0010) $display("FAIL read_req%0d got=%b exp=0010", k, DEV_Req); else pass_cnt++;
      total++; if (DEV_Addr !== 4'd4) $display("FAIL read_addr%0d got=%h exp=4", k, DEV_Addr); else pass_cnt++;
      total++; if (PrRD !== 32'd0) $display("FAIL read_rd_req%0d got=%h exp=0", k, PrRD); else pass_cnt++;
    end
    tick();
    DEV_Ack = 4'b0000;
    #1;
    if (PrStall) stall_n++;
    total++; if (PrRD !== 32'hDEAD_BEEF) $display("FAIL read_done_rd got=%h exp=deadbeef", PrRD); else pass_cnt++;
    total++; if (PrBusErr !== 1'b0) $display("FAIL read_done_err got=%b exp=0", PrBusErr); else pass_cnt++;
    total++; if (DEV_Req !== 4'b0000) $display("FAIL read_done_req got=%b exp=0000", DEV_Req); else pass_cnt++;
    total++; if (stall_n != 4) $display("FAIL read_stall_cycles got=%0d exp=4", stall_n); else pass_cnt++;
    tick();
    PrRE = 1'b0; PrAddr = 32'd0;
    #1;
    total++; if (PrRD !== 32'd0) $display("FAIL read_after_rd got=%h exp=0", PrRD); else pass_cnt++;
  endtask

  task automatic test_write();
    tick();
    PrWE = 1'b1; PrAddr = 32'h0000_7F08; PrWD = 32'h1234_5678; PrBE = 4'hF;
    #1;
    total++; if (PrStall !== 1'b1) $display("FAIL write_idle_stall got=%b exp=1", PrStall); else pass_cnt++;
    tick();
    DEV_Ack = 4'b0001;
    #1;
    total++; if (DEV_Req !== 4'b0001) $display("FAIL write_req got=%b exp=0001", DEV_Req); else pass_cnt++;
    total++; if (DEV_WE !== 1'b1) $display("FAIL write_we got=%b exp=1", DEV_WE); else pass_cnt++;
    total++; if (DEV_WD !== 32'h1234_5678) $display("FAIL write_wd got=%h exp=12345678", DEV_WD); else pass_cnt++;
    total++; if (DEV_BE !== 4'hF) $display("FAIL write_be got=%h exp=f", DEV_BE); else pass_cnt++;
    total++; if (DEV_Addr !== 4'd8) $display("FAIL write_addr got=%h exp=8", DEV_Addr); else pass_cnt++;
    tick();
    DEV_Ack = 4'b0000;
    #1;
    total++; if (PrRD !== 32'd0) $display("FAIL write_done_rd got=%h exp=0", PrRD); else pass_cnt++;
    total++; if (PrStall !== 1'b0) $display("FAIL write_done_stall got=%b exp=0", PrStall); else pass_cnt++;
    tick();
    PrWE = 1'b0; PrAddr = 32'd0;
  endtask

  task automatic test_timeout();
    int  stall_n = 0;
    bit  err_seen = 1'b0;
    bit  req_ok = 1'b1;
    tick();
    PrRE = 1'b1; PrAddr = 32'h0000_7F20;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (PrBusErr) begin
        err_seen = 1'b1;
        break;
      end
      if (PrStall) stall_n++;
      if (c > 0 && DEV_Req !== 4'b0100) req_ok = 1'b0;
      tick();
      #1;
    end
    total++; if (err_seen !== 1'b1) $display("FAIL timeout_err_seen got=%b exp=1", err_seen); else pass_cnt++;
    total++; if (stall_n != 16) $display("FAIL timeout_stall_cycles got=%0d exp=16", stall_n); else pass_cnt++;
    total++; if (req_ok !== 1'b1) $display("FAIL timeout_req_held got=%b exp=1", req_ok); else pass_cnt++;
    total++; if (DEV_Req !== 4'b0000) $display("FAIL timeout_err_req got=%b exp=0000", DEV_Req); else pass_cnt++;
    total++; if (PrStall !== 1'b0) $display("FAIL timeout_err_stall got=%b exp=0", PrStall); else pass_cnt++;
    total++; if (PrRD !== 32'd0) $display("FAIL timeout_err_rd got=%h exp=0", PrRD); else pass_cnt++;
    tick();
    PrRE = 1'b0; PrAddr = 32'd0; DEV_Ack = 4'b0100;
    #1;
    total++; if (PrBusErr !== 1'b0) $display("FAIL timeout_pulse_len got=%b exp=0", PrBusErr); else pass_cnt++;
    total++; if (DEV_Req !== 4'b0000) $display("FAIL timeout_late_req got=%b exp=0000", DEV_Req); else pass_cnt++;
    tick();
    DEV_Ack = 4'b0000;
    #1;
    total++; if (PrRD !== 32'd0) $display("FAIL timeout_late_rd got=%h exp=0", PrRD); else pass_cnt++;
    total++; if (PrStall !== 1'b0) $display("FAIL timeout_late_stall got=%b exp=0", PrStall); else pass_cnt++;
  endtask

  task automatic test_unmapped();
    tick();
    PrRE = 1'b1; PrAddr = 32'h0000_7F50;
    #1;
    total++; if (PrStall !== 1'b0) $display("FAIL unmapped_stall got=%b exp=0", PrStall); else pass_cnt++;
    total++; if (PrBusErr !== 1'b0) $display("FAIL unmapped_err_early got=%b exp=0", PrBusErr); else pass_cnt++;
    tick();
    PrRE = 1'b0; PrAddr = 32'd0;
    #1;
    total++; if (PrBusErr !== 1'b1) $display("FAIL unmapped_err got=%b exp=1", PrBusErr); else pass_cnt++;
    total++; if (PrStall !== 1'b0) $display("FAIL unmapped_err_stall got=%b exp=0", PrStall); else pass_cnt++;
    total++; if (DEV_Req !== 4'b0000) $display("FAIL unmapped_req got=%b exp=0000", DEV_Req); else pass_cnt++;
    tick();
    #1;
    total++; if (PrBusErr !== 1'b0) $display("FAIL unmapped_err_len got=%b exp=0", PrBusErr); else pass_cnt++;
  endtask

  task automatic test_irq_window();
    tick();
    DEV_Irq = 4'b1001;
    #1;
    total++; if (HWInt !== 6'b000000) $display("FAIL irq_same_cycle got=%b exp=000000", HWInt); else pass_cnt++;
    tick();
    PrRE = 1'b1; PrAddr = 32'h0000_1000;
    #1;
    total++; if (HWInt !== 6'b001001) $display("FAIL irq_registered got=%b exp=001001", HWInt); else pass_cnt++;
    total++; if (PrStall !== 1'b0) $display("FAIL outwin_stall got=%b exp=0", PrStall); else pass_cnt++;
    tick();
    PrAddr = 32'h0000_7F60;
    #1;
    total++; if (DEV_Req !== 4'b0000) $display("FAIL outwin_req got=%b exp=0000", DEV_Req); else pass_cnt++;
    total++; if (PrBusErr !== 1'b0) $display("FAIL outwin_err got=%b exp=0", PrBusErr); else pass_cnt++;
    total++; if (PrStall !== 1'b0) $display("FAIL outwin_edge_stall got=%b exp=0", PrStall); else pass_cnt++;
    tick();
    PrRE = 1'b0; PrAddr = 32'd0;
    #1;
    total++; if (PrBusErr !== 1'b0) $display("FAIL outwin_edge_err got=%b exp=0", PrBusErr); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tick();
    DEV_Irq = 4'b0110;
    PrRE = 1'b1; PrAddr = 32'h0000_7F30;
    DEV_RD[127:96] = 32'hCAFE_F00D;
    tick();
    tick();
    #1;
    total++; if (DEV_Req !== 4'b1000) $display("FAIL rstmid_req_before got=%b exp=1000", DEV_Req); else pass_cnt++;
    total++; if (HWInt !== 6'b000110) $display("FAIL rstmid_hwint_before got=%b exp=000110", HWInt); else pass_cnt++;
    Reset = 1'b0;
    #1;
    total++; if (DEV_Req !== 4'b0000) $display("FAIL rstmid_req got=%b exp=0000", DEV_Req); else pass_cnt++;
    total++; if (PrStall !== 1'b0) $display("FAIL rstmid_stall got=%b exp=0", PrStall); else pass_cnt++;
    total++; if (PrRD !== 32'd0) $display("FAIL rstmid_rd got=%h exp=0", PrRD); else pass_cnt++;
    total++; if (HWInt !== 6'b000000) $display("FAIL rstmid_hwint got=%b exp=000000", HWInt); else pass_cnt++;
    total++; if (DEV_Addr !== 4'd0) $display("FAIL rstmid_addr got=%h exp=0", DEV_Addr); else pass_cnt++;
    tick();
    Reset = 1'b1;
    #1;
    total++; if (PrStall !== 1'b1) $display("FAIL rstmid_idle_stall got=%b exp=1", PrStall); else pass_cnt++;
    total++; if (DEV_Req !== 4'b0000) $display("FAIL rstmid_idle_req got=%b exp=0000", DEV_Req); else pass_cnt++;
    tick();
    DEV_Ack = 4'b1000;
    #1;
    total++; if (DEV_Req !== 4'b1000) $display("FAIL rstmid_new_req got=%b exp=1000", DEV_Req); else pass_cnt++;
    tick();
    DEV_Ack = 4'b0000;
    #1;
    total++; if (PrRD !== 32'hCAFE_F00D) $display("FAIL rstmid_new_rd got=%h exp=cafef00d", PrRD); else pass_cnt++;
    total++; if (PrStall !== 1'b0) $display("FAIL rstmid_new_stall got=%b exp=0", PrStall); else pass_cnt++;
    tick();
    PrRE = 1'b0; PrAddr = 32'd0;
  endtask

  initial begin
    Reset   = 1'b0;
    PrAddr  = 32'd0;
    PrWD    = 32'd0;
    PrBE    = 4'd0;
    PrWE    = 1'b0;
    PrRE    = 1'b0;
    DEV_Ack = 4'd0;
    DEV_RD  = '0;
    DEV_Irq = 4'd0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_unmapped();
    test_irq_window();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
